// File: rtl/afe_ads_pkg.sv
// afe_ads_pkg: shared types and constants for the AFE/ADS acquisition sequencer.
//   state_e      top-level frame sequencer states
//   rx_phase_e   serial readout phases inside ads_serial_rx
//   WORD_W/TAG_W captured word width and channel-tag width
//   *_VAL        static strap levels driven on AFE/ADS pins at all times
package afe_ads_pkg;

  localparam int WORD_W = 18;
  localparam int TAG_W  = 2;

  localparam logic [2:0] AFE_PGA_VAL    = 3'b000;
  localparam logic [1:0] ADS_M_VAL      = 2'b00;
  localparam logic       AFE_PDZ_VAL    = 1'b1;
  localparam logic       AFE_NAPZ_VAL   = 1'b1;
  localparam logic       AFE_ENTRI_VAL  = 1'b0;
  localparam logic       AFE_SMT_MD_VAL = 1'b0;
  localparam logic       AFE_INPUTZ_VAL = 1'b0;
  localparam logic       AFE_DF_SM_VAL  = 1'b1;
  localparam logic       ADS_SDI_VAL    = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_IRST,
    ST_SHR,
    ST_INTG,
    ST_SHS,
    ST_CONV,
    ST_WAITB,
    ST_RD,
    ST_SHIFT,
    ST_NEXT
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RD,
    RX_GAP,
    RX_SHIFT
  } rx_phase_e;

  // Channel tag carried in the top bits of each ADC word.
  function automatic logic [TAG_W-1:0] word_tag(input logic [WORD_W-1:0] w);
    return w[WORD_W-1 -: TAG_W];
  endfunction

endpackage

// File: rtl/afe_ads_top_ads_serial_rx.sv
// ads_serial_rx: one read cycle of the dual-channel serial SAR ADC.
// On start it drops CS_N, strobes RD for 2 cycles, idles 2 cycles, then
// generates 18 ADS_CLK periods (high half first) and shifts SDOA/SDOB in
// MSB first on the edge that drives ADS_CLK low. done pulses for one cycle
// as CS_N returns high; word_a/word_b hold the shifted words until the next read.
// Ports:
//   sys_clk, sys_rst     clock, synchronous active-high reset
//   start                begin a read (ignored unless idle)
//   sdoa, sdob           serial data from the ADC
//   cs_n, rd, ads_clk    registered ADC control pins
//   shifting             high while ADS_CLK is being generated
//   done                 one-cycle pulse at end of the window
//   word_a, word_b       shifted words
module ads_serial_rx
  import afe_ads_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              sdoa,
  input  logic              sdob,
  output logic              cs_n,
  output logic              rd,
  output logic              ads_clk,
  output logic              shifting,
  output logic              done,
  output logic [WORD_W-1:0] word_a,
  output logic [WORD_W-1:0] word_b
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(WORD_W);

  rx_phase_e         phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic              cs_n_q, cs_n_d, rd_q, rd_d, ads_clk_q, ads_clk_d, done_q, done_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      cs_n_q    <= 1'b1;
      rd_q      <= 1'b0;
      ads_clk_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      cs_n_q    <= cs_n_d;
      rd_q      <= rd_d;
      ads_clk_q <= ads_clk_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    cs_n_d    = cs_n_q;
    rd_d      = rd_q;
    ads_clk_d = ads_clk_q;
    done_d    = 1'b0;
    case (phase_q)
      RX_IDLE: begin
        if (start) begin
          phase_d = RX_RD;
          cnt_d   = CNT_W'(1);
          cs_n_d  = 1'b0;
          rd_d    = 1'b1;
        end
      end
      RX_RD: begin
        if (cnt_q == '0) begin
          phase_d = RX_GAP;
          cnt_d   = CNT_W'(1);
          rd_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_GAP: begin
        if (cnt_q == '0) begin
          phase_d   = RX_SHIFT;
          cnt_d     = CNT_W'(CLK_DIV - 1);
          bit_d     = BIT_W'(WORD_W - 1);
          ads_clk_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_SHIFT: begin
        // cnt counts down through one ADS_CLK period; the mid-period edge
        // drops ADS_CLK and is where the bit launched at the rise is stable.
        if (cnt_q == CNT_W'(HALF)) begin
          ads_clk_d = 1'b0;
          sh_a_d    = {sh_a_q[WORD_W-2:0], sdoa};
          sh_b_d    = {sh_b_q[WORD_W-2:0], sdob};
        end
        if (cnt_q == '0) begin
          if (bit_q == '0) begin
            phase_d = RX_IDLE;
            cs_n_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            bit_d     = bit_q - 1'b1;
            cnt_d     = CNT_W'(CLK_DIV - 1);
            ads_clk_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: phase_d = RX_IDLE;
    endcase
  end

  assign cs_n     = cs_n_q;
  assign rd       = rd_q;
  assign ads_clk  = ads_clk_q;
  assign shifting = (phase_q == RX_SHIFT);
  assign done     = done_q;
  assign word_a   = sh_a_q;
  assign word_b   = sh_b_q;

endmodule

// File: rtl/afe_ads_top.sv
// afe_ads_top: free-running acquisition sequencer for the charge-integrating
// AFE and dual-channel serial SAR ADC. Each frame resets the integrators,
// samples reset and signal levels around the integration window, then
// converts and reads out N_CH channels, advancing the AFE once per channel.
// Ports: AFE_* / ADS_* board pins (all registered or constant), sys_clk,
// sys_rst (sync, active high), word_a/word_b/word_valid captured words for
// downstream logic, afe_sts registered {AFE_STO, AFE_EOC}.
//
// state  | meaning
// IDLE   | one cycle between frames
// IRST   | integrator reset, T_IRST cycles
// SHR    | reset-level sample, T_SH cycles
// INTG   | integration, T_INTG cycles
// SHS    | signal-level sample, T_SH cycles; channel count cleared
// CONV   | one-cycle CONVST pulse
// WAITB  | minimum 2 cycles, then until BUSY low
// RD     | RD strobe and pre-clock gap (handled by ads_serial_rx)
// SHIFT  | 18 ADS_CLK periods of serial readout
// NEXT   | latch words, AFE_CLK pulse 2 cycles, next channel or new frame
module afe_ads_top
  import afe_ads_pkg::*;
#(
  parameter int ADS_CLK_DIV = 4,
  parameter int N_CH        = 64,
  parameter int T_IRST      = 16,
  parameter int T_SH        = 8,
  parameter int T_INTG      = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  output logic              AFE_CLK,
  output logic              AFE_INTG,
  output logic              AFE_IRST,
  output logic              AFE_SHS,
  output logic              AFE_SHR,
  output logic              AFE_PDZ,
  output logic              AFE_NAPZ,
  output logic              AFE_ENTRI,
  output logic              AFE_SMT_MD,
  output logic              AFE_INPUTZ,
  output logic              AFE_DF_SM,
  output logic [2:0]        AFE_PGA,
  input  logic              AFE_STO,
  input  logic              AFE_EOC,
  output logic              ADS_CLK,
  output logic              ADS_CS_N,
  output logic              ADS_CONVST,
  input  logic              ADS_BUSY,
  output logic              ADS_RD,
  output logic              ADS_SDI,
  output logic [1:0]        ADS_M,
  input  logic              ADS_SDOA,
  input  logic              ADS_SDOB,
  output logic [WORD_W-1:0] word_a,
  output logic [WORD_W-1:0] word_b,
  output logic              word_valid,
  output logic [1:0]        afe_sts
);

  localparam int TMR_W = 16;
  localparam int CH_W  = $clog2(N_CH + 1);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              busy_q, sto_q, eoc_q;
  logic              afe_clk_q, afe_clk_d, afe_intg_q, afe_intg_d, afe_irst_q, afe_irst_d;
  logic              afe_shs_q, afe_shs_d, afe_shr_q, afe_shr_d, convst_q, convst_d;
  logic [WORD_W-1:0] word_a_q, word_a_d, word_b_q, word_b_d;
  logic              word_valid_q, word_valid_d;

  logic              rx_start, rx_shifting, rx_done;
  logic [WORD_W-1:0] rx_word_a, rx_word_b;

  ads_serial_rx #(
    .CLK_DIV (ADS_CLK_DIV)
  ) u_rx (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (rx_start),
    .sdoa     (ADS_SDOA),
    .sdob     (ADS_SDOB),
    .cs_n     (ADS_CS_N),
    .rd       (ADS_RD),
    .ads_clk  (ADS_CLK),
    .shifting (rx_shifting),
    .done     (rx_done),
    .word_a   (rx_word_a),
    .word_b   (rx_word_b)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      ch_q         <= '0;
      busy_q       <= 1'b0;
      sto_q        <= 1'b0;
      eoc_q        <= 1'b0;
      afe_clk_q    <= 1'b0;
      afe_intg_q   <= 1'b0;
      afe_irst_q   <= 1'b0;
      afe_shs_q    <= 1'b0;
      afe_shr_q    <= 1'b0;
      convst_q     <= 1'b0;
      word_a_q     <= '0;
      word_b_q     <= '0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      ch_q         <= ch_d;
      busy_q       <= ADS_BUSY;
      sto_q        <= AFE_STO;
      eoc_q        <= AFE_EOC;
      afe_clk_q    <= afe_clk_d;
      afe_intg_q   <= afe_intg_d;
      afe_irst_q   <= afe_irst_d;
      afe_shs_q    <= afe_shs_d;
      afe_shr_q    <= afe_shr_d;
      convst_q     <= convst_d;
      word_a_q     <= word_a_d;
      word_b_q     <= word_b_d;
      word_valid_q <= word_valid_d;
    end
  end

  // Timed states load (length-1) on entry and leave when the down-counter hits 0.
  always_comb begin
    state_d  = state_q;
    tmr_d    = (tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
    ch_d     = ch_q;
    rx_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IRST;
        tmr_d   = TMR_W'(T_IRST - 1);
      end
      ST_IRST: if (tmr_q == '0) begin
        state_d = ST_SHR;
        tmr_d   = TMR_W'(T_SH - 1);
      end
      ST_SHR: if (tmr_q == '0) begin
        state_d = ST_INTG;
        tmr_d   = TMR_W'(T_INTG - 1);
      end
      ST_INTG: if (tmr_q == '0) begin
        state_d = ST_SHS;
        tmr_d   = TMR_W'(T_SH - 1);
      end
      ST_SHS: begin
        ch_d = '0;
        if (tmr_q == '0) state_d = ST_CONV;
      end
      ST_CONV: begin
        state_d = ST_WAITB;
        tmr_d   = TMR_W'(1);
      end
      ST_WAITB: if (tmr_q == '0 && !busy_q) begin
        state_d  = ST_RD;
        rx_start = 1'b1;
      end
      ST_RD: if (rx_shifting) state_d = ST_SHIFT;
      ST_SHIFT: if (rx_done) begin
        state_d = ST_NEXT;
        tmr_d   = TMR_W'(1);
        ch_d    = ch_q + 1'b1;
      end
      ST_NEXT: if (tmr_q == '0) begin
        state_d = (ch_q == CH_W'(N_CH)) ? ST_IDLE : ST_CONV;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin levels follow the state being entered so they register in step with it.
  always_comb begin
    afe_irst_d   = (state_d == ST_IRST);
    afe_shr_d    = (state_d == ST_SHR);
    afe_intg_d   = (state_d == ST_INTG);
    afe_shs_d    = (state_d == ST_SHS);
    convst_d     = (state_d == ST_CONV);
    afe_clk_d    = (state_d == ST_NEXT);
    word_valid_d = (state_q == ST_SHIFT) && (state_d == ST_NEXT);
    word_a_d     = word_valid_d ? rx_word_a : word_a_q;
    word_b_d     = word_valid_d ? rx_word_b : word_b_q;
  end

  assign AFE_CLK    = afe_clk_q;
  assign AFE_INTG   = afe_intg_q;
  assign AFE_IRST   = afe_irst_q;
  assign AFE_SHS    = afe_shs_q;
  assign AFE_SHR    = afe_shr_q;
  assign ADS_CONVST = convst_q;
  assign word_a     = word_a_q;
  assign word_b     = word_b_q;
  assign word_valid = word_valid_q;
  assign afe_sts    = {sto_q, eoc_q};

  assign AFE_PDZ    = AFE_PDZ_VAL;
  assign AFE_NAPZ   = AFE_NAPZ_VAL;
  assign AFE_ENTRI  = AFE_ENTRI_VAL;
  assign AFE_SMT_MD = AFE_SMT_MD_VAL;
  assign AFE_INPUTZ = AFE_INPUTZ_VAL;
  assign AFE_DF_SM  = AFE_DF_SM_VAL;
  assign AFE_PGA    = AFE_PGA_VAL;
  assign ADS_SDI    = ADS_SDI_VAL;
  assign ADS_M      = ADS_M_VAL;

endmodule

// File: tb/tb_afe_ads_top.sv
module tb_afe_ads_top;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        AFE_CLK, AFE_INTG, AFE_IRST, AFE_SHS, AFE_SHR;
  logic        AFE_PDZ, AFE_NAPZ, AFE_ENTRI, AFE_SMT_MD, AFE_INPUTZ, AFE_DF_SM;
  logic [2:0]  AFE_PGA;
  logic        AFE_STO = 1'b0, AFE_EOC = 1'b0;
  logic        ADS_CLK, ADS_CS_N, ADS_CONVST, ADS_RD, ADS_SDI;
  logic        ADS_BUSY = 1'b0, ADS_SDOA = 1'b0, ADS_SDOB = 1'b0;
  logic [1:0]  ADS_M;
  logic [17:0] word_a, word_b;
  logic        word_valid;
  logic [1:0]  afe_sts;

  always #10 sys_clk = ~sys_clk;

  afe_ads_top #(
    .ADS_CLK_DIV (4),
    .N_CH        (64),
    .T_IRST      (16),
    .T_SH        (8),
    .T_INTG      (256)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .AFE_CLK    (AFE_CLK),
    .AFE_INTG   (AFE_INTG),
    .AFE_IRST   (AFE_IRST),
    .AFE_SHS    (AFE_SHS),
    .AFE_SHR    (AFE_SHR),
    .AFE_PDZ    (AFE_PDZ),
    .AFE_NAPZ   (AFE_NAPZ),
    .AFE_ENTRI  (AFE_ENTRI),
    .AFE_SMT_MD (AFE_SMT_MD),
    .AFE_INPUTZ (AFE_INPUTZ),
    .AFE_DF_SM  (AFE_DF_SM),
    .AFE_PGA    (AFE_PGA),
    .AFE_STO    (AFE_STO),
    .AFE_EOC    (AFE_EOC),
    .ADS_CLK    (ADS_CLK),
    .ADS_CS_N   (ADS_CS_N),
    .ADS_CONVST (ADS_CONVST),
    .ADS_BUSY   (ADS_BUSY),
    .ADS_RD     (ADS_RD),
    .ADS_SDI    (ADS_SDI),
    .ADS_M      (ADS_M),
    .ADS_SDOA   (ADS_SDOA),
    .ADS_SDOB   (ADS_SDOB),
    .word_a     (word_a),
    .word_b     (word_b),
    .word_valid (word_valid),
    .afe_sts    (afe_sts)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  function automatic logic pin(input int idx);
    case (idx)
      0: return AFE_IRST;
      1: return AFE_SHR;
      2: return AFE_INTG;
      3: return AFE_SHS;
      4: return ADS_CS_N;
      7: return ADS_CONVST;
      default: return 1'bx;
    endcase
  endfunction

  task automatic wait_pin(input int idx, input logic val, input int lim, input string nm);
    int n = 0;
    while (pin(idx) !== val && n < lim) begin
      @(negedge sys_clk);
      n++;
    end
    if (pin(idx) !== val) timeout_fail(nm);
  endtask

  task automatic pulse_width(input int idx, input int exp, input string nm);
    int w = 0;
    wait_pin(idx, 1'b1, 2000, nm);
    while (pin(idx) === 1'b1 && w < 2000) begin
      w++;
      @(negedge sys_clk);
    end
    check(nm, w, exp);
  endtask

  // ADC model: word {cnt[1:0], cnt+1} loaded on RD rise, MSB launched per ADS_CLK rise.
  int unsigned  adc_cnt = 0;
  logic [17:0]  adc_sh = '0;
  logic [17:0]  exp_q[$];
  bit           long_busy_req = 0, long_busy_active = 0, long_busy_done = 0;
  longint       t_long_conv = 0, t_long_rd = 0;

  always @(posedge ADS_RD) begin
    adc_sh = {adc_cnt[1:0], 16'(adc_cnt + 1)};
    exp_q.push_back(adc_sh);
    adc_cnt++;
    check("rd_rise_busy_low", ADS_BUSY, 1'b0);
    if (long_busy_active) begin
      t_long_rd        = $time;
      long_busy_active = 0;
      long_busy_done   = 1;
    end
  end

  always @(posedge ADS_CLK) begin
    ADS_SDOA = adc_sh[17];
    ADS_SDOB = adc_sh[17];
    adc_sh   = {adc_sh[16:0], 1'b0};
  end

  always @(posedge ADS_CONVST) begin
    int len;
    len = 3;
    if (long_busy_req) begin
      len              = 50;
      long_busy_req    = 0;
      long_busy_active = 1;
      t_long_conv      = $time;
    end
    @(negedge sys_clk);
    ADS_BUSY = 1'b1;
    repeat (len) @(negedge sys_clk);
    ADS_BUSY = 1'b0;
  end

  // ADS_CLK rises per chip-select window.
  int clk_rises = 0;
  bit ignore_win = 1;
  always @(negedge ADS_CS_N) clk_rises = 0;
  always @(posedge ADS_CLK) clk_rises++;
  always @(posedge ADS_CS_N) if (!ignore_win) check("ads_clk_rises_per_cs", clk_rises, 18);

  // Per-frame pulse counts, snapshotted at each integrator-reset start.
  int afe_clk_n = 0, convst_n = 0, frame_afe_clk = -1, frame_convst = -1, irst_rises = 0;
  always @(posedge AFE_CLK) afe_clk_n++;
  always @(posedge ADS_CONVST) convst_n++;
  always @(posedge AFE_IRST) begin
    frame_afe_clk = afe_clk_n;
    frame_convst  = convst_n;
    afe_clk_n     = 0;
    convst_n      = 0;
    irst_rises++;
  end

  // Scoreboard monitor.
  logic [17:0] seen[$];
  always @(negedge sys_clk) begin
    if (word_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got a=0x%0h b=0x%0h, required no word", word_a, word_b);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("word_a", word_a, e);
        check("word_b", word_b, e);
      end
      seen.push_back(word_a);
    end
  end

  initial begin
    #(20 * 60000);
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int base;
    longint dly;
    sys_rst = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("rst_pdz", AFE_PDZ, 1'b1);
    check("rst_napz", AFE_NAPZ, 1'b1);
    check("rst_entri", AFE_ENTRI, 1'b0);
    check("rst_pga", AFE_PGA, 3'b000);
    check("rst_m", ADS_M, 2'b00);
    check("rst_sdi", ADS_SDI, 1'b0);
    check("rst_straps", {AFE_SMT_MD, AFE_INPUTZ, AFE_DF_SM}, 3'b001);
    check("rst_cs_n", ADS_CS_N, 1'b1);
    check("rst_ads_clk", ADS_CLK, 1'b0);
    check("rst_ctl", {AFE_CLK, AFE_INTG, AFE_IRST, AFE_SHS, AFE_SHR, ADS_RD, ADS_CONVST}, 7'b0);
    check("rst_word", {word_valid, word_a, word_b}, 37'b0);
    AFE_STO = 1'b1;
    sys_rst = 1'b0;
    ignore_win = 0;

    pulse_width(0, 16, "irst_width");
    check("seq_irst_to_shr", AFE_SHR, 1'b1);
    pulse_width(1, 8, "shr_width");
    check("seq_shr_to_intg", AFE_INTG, 1'b1);
    pulse_width(2, 256, "intg_width");
    check("seq_intg_to_shs", AFE_SHS, 1'b1);
    pulse_width(3, 8, "shs_width");
    check("seq_shs_to_conv", ADS_CONVST, 1'b1);
    check("afe_sts", afe_sts, 2'b10);

    n = 0;
    while (seen.size() < 5 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    if (seen.size() < 5) timeout_fail("first_words");
    else begin
      check("first_word", seen[0], 18'h00001);
      check("second_word", seen[1], 18'h10002);
      check("tag_wrap_word5", seen[4], 18'h00005);
    end

    long_busy_req = 1;
    n = 0;
    while (!long_busy_done && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    if (!long_busy_done) timeout_fail("long_busy_rd");
    else begin
      dly = (t_long_rd - t_long_conv) / 20;
      check("long_busy_rd_delay_ok", (dly >= 51 && dly <= 54), 1'b1);
    end

    n = 0;
    while (irst_rises < 2 && n < 10000) begin
      @(negedge sys_clk);
      n++;
    end
    if (irst_rises < 2) timeout_fail("frame_end");
    else begin
      check("frame_afe_clk_pulses", frame_afe_clk, 64);
      check("frame_convst_pulses", frame_convst, 64);
    end

    // Abort a readout in the middle of its ADS_CLK burst.
    wait_pin(4, 1'b0, 2000, "cs_low_frame2");
    repeat (12) @(negedge sys_clk);
    check("abort_in_window", ADS_CS_N, 1'b0);
    ignore_win = 1;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    exp_q.delete();
    check("abort_cs_n", ADS_CS_N, 1'b1);
    check("abort_ads_clk", ADS_CLK, 1'b0);
    check("abort_no_valid", word_valid, 1'b0);
    check("abort_no_word", word_a, 18'h0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("restart_irst", AFE_IRST, 1'b1);
    pulse_width(0, 16, "restart_irst_width");
    ignore_win = 0;

    base = seen.size();
    n = 0;
    while (seen.size() < base + 2 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    if (seen.size() < base + 2) timeout_fail("words_after_restart");
    check("run_static_pins", {AFE_PDZ, AFE_NAPZ, AFE_ENTRI, AFE_PGA, ADS_M, ADS_SDI}, 9'b110000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
